mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised multi-cycle multiply/divide unit with HI/LO registers for the five-stage MIPS pipeline. It sits in EX beside the ALU and is launched by a one-cycle start pulse from the E-stage controller. It drives a busy flag that the conflict manager uses to stall D-stage mfhi/mflo/mult/div. It is the width- and latency-generalised successor of the fixed single-cycle HI/LO path.

## Interface
- XLEN, 32: operand/HI/LO width; ≥ 8, even.
- MUL_CYCLES, 5: multiply busy duration in cycles; ≥ 1.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. One clock; polarity and synchronicity fixed.
- start  in  1  one-cycle launch strobe; sampled only when busy=0.
- op  in  4  MULT, MULTU, DIV, DIVU, MTHI, MTLO (+ MADD, MADDU, MSUB, MSUBU with macro).
- a  in  XLEN  rs operand, forwarded value.
- b  in  XLEN  rt operand, forwarded value.
- busy  out  1  high while a multiply or divide is in flight.
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX. Cycle counter width $clog2(max(MUL_CYCLES, XLEN)+1).
- IDLE + start + MTHI/MTLO: hi (or lo) ← a at the same edge; no busy; stays IDLE.
- IDLE + start + MULT/MULTU: 2·XLEN product of a, b (signed/unsigned) latched into internal product register; → MUL; counter ← MUL_CYCLES−1.
- MUL: counter decrements; at 0, {hi,lo} ← product; → IDLE.
- IDLE + start + DIV/DIVU: latch |a|, |b| (signed) or raw; record quotient sign (a^b) and remainder sign (a); → DIV.
- DIV: radix-2 restoring step per cycle for XLEN cycles; → FIX.
- FIX: apply signs, write lo ← quotient, hi ← remainder; → IDLE.
- Signed rules: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (b=0): lo ← all ones, hi ← a; full latency still taken.
- Signed overflow (a=INT_MIN, b=−1): lo ← INT_MIN, hi ← 0.
- start while busy=1: ignored entirely; no queueing.
- Unknown op with start: ignored; stays IDLE.
- hi/lo are never modified except at the completion edge or by MTHI/MTLO.

## Timing
- Reset (async, any state, mid-operation included): state IDLE, busy=0, hi=0, lo=0, counter=0, partials cleared; in-flight operation discarded.
- busy registered: rises the edge after start; falls on the edge that writes hi/lo.
- New hi/lo are visible in the same cycle busy reads 0.
- Multiply: busy high for MUL_CYCLES cycles.
- Divide: busy high for XLEN+1 cycles.
- MTHI/MTLO: hi/lo visible the cycle after start; busy never asserts.
- Back-to-back: a start in the first cycle with busy=0 is accepted (zero-gap).
- Conflict manager stalls D on (busy | start) for any HI/LO-using instruction.

## Configuration
- MDU_MADD_EN defined: MADD/MADDU/MSUB/MSUBU enabled. On the MUL completion edge, {hi,lo} ← {hi,lo} ± product, wrapping mod 2^(2·XLEN). Same latency as MULT.
- Undefined: those op encodings are treated as unknown and ignored; the accumulator adder is not built.

## Structure
- mdu_pkg holds:
  - op encoding localparams (MDU_MULT … MDU_MSUBU);
  - state enum {IDLE, MUL, DIV, FIX};
  - constant functions for counter width.
- Sub-module mdu_div_core: iterative unsigned XLEN-bit divider with load/step/done. The top handles signs, the FSM, and HI/LO.

## Test plan
- XLEN=32, MUL_CYCLES=5, MULT a=0xFFFFFFFD, b=5 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU a=100, b=7 -> busy high 33 cycles, then lo=14, hi=2. DIV a=−7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x1234, b=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x1234. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTLO a=0x10 with MTHI a=0, then MADDU a=2, b=3 (MDU_MADD_EN) -> lo=0x16, hi=0. Without macro -> op ignored, busy stays 0.
- Start DIV, pulse start with MULT at cycle 4 -> second start ignored, divide result correct. Reset low at cycle 10 -> busy=0, hi=lo=0 immediately, no later write.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mdu_pkg : op encodings, FSM state type and counter sizing for mdu_iter |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package mdu_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MTHI  = 4'd4;
  localparam logic [3:0] MDU_MTLO  = 4'd5;
  localparam logic [3:0] MDU_MADD  = 4'd6;
  localparam logic [3:0] MDU_MADDU = 4'd7;
  localparam logic [3:0] MDU_MSUB  = 4'd8;
  localparam logic [3:0] MDU_MSUBU = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  function automatic int cnt_width(input int mul_cycles, input int xlen);
    int m;
    m = (mul_cycles > xlen) ? mul_cycles : xlen;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mdu_iter_if : launch/operand/result bundle between E-stage and MDU     |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface mdu_iter_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [3:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface
`default_nettype wire

// File: rtl/mdu_div_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mdu_div_core : iterative unsigned restoring divider, one bit per step  |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mdu_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem,
  output logic            o_last
);
  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] r_quot, r_rem, r_div, w_diff;
  logic [XLEN:0]   w_shift;
  logic [CW-1:0]   r_cnt;
  logic            w_ge;

  // Dividend bits enter the remainder from the quotient register's MSB.
  assign w_shift = {r_rem, r_quot[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift[XLEN-1:0] - r_div;
  assign o_last  = (r_cnt == CW'(XLEN - 1));
  assign o_quot  = r_quot;
  assign o_rem   = r_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_quot <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_cnt  <= '0;
    end else if (i_step) begin
      r_quot <= {r_quot[XLEN-2:0], w_ge};
      r_rem  <= w_ge ? w_diff : w_shift[XLEN-1:0];
      r_cnt  <= r_cnt + CW'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mdu_iter : multi-cycle MIPS multiply/divide unit with HI/LO registers  |
// | Optional MADD/MADDU/MSUB/MSUBU accumulate via `define MDU_MADD_EN      |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic      clk,
  input  logic      reset,
  mdu_iter_if.slave bus
);
  localparam int            CW         = cnt_width(MUL_CYCLES, XLEN);
  localparam logic [CW-1:0] c_MUL_LOAD = CW'(MUL_CYCLES - 1);

  mdu_state_e        r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_prod, w_prod, w_mul_res, w_ext_a, w_ext_b;
  logic [XLEN-1:0]   r_hi, r_lo, r_a_raw;
  logic [XLEN-1:0]   w_abs_a, w_abs_b, w_quot, w_rem, w_q_fix, w_r_fix;
  logic              r_qneg, r_rneg, r_dz;
  logic              w_accept, w_is_mul, w_is_div, w_signed, w_div_last;

  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_signed = 1'b0;
    case (bus.op)
      MDU_MULT:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
      MDU_MULTU: w_is_mul = 1'b1;
      MDU_DIV:   begin w_is_div = 1'b1; w_signed = 1'b1; end
      MDU_DIVU:  w_is_div = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MSUB:   begin w_is_mul = 1'b1; w_signed = 1'b1; end
      MDU_MADDU, MDU_MSUBU: w_is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  assign w_accept = bus.start && (r_state == ST_IDLE);

  // Sign-extending to 2*XLEN lets one unsigned multiplier serve both flavours.
  assign w_ext_a = {{XLEN{w_signed & bus.a[XLEN-1]}}, bus.a};
  assign w_ext_b = {{XLEN{w_signed & bus.b[XLEN-1]}}, bus.b};
  assign w_prod  = w_ext_a * w_ext_b;

  assign w_abs_a = (w_signed && bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign w_abs_b = (w_signed && bus.b[XLEN-1]) ? -bus.b : bus.b;
  assign w_q_fix = r_qneg ? -w_quot : w_quot;
  assign w_r_fix = r_rneg ? -w_rem : w_rem;

`ifdef MDU_MADD_EN
  logic r_acc, r_sub;
  always_comb begin
    w_mul_res = r_prod;
    if (r_acc) w_mul_res = r_sub ? ({r_hi, r_lo} - r_prod) : ({r_hi, r_lo} + r_prod);
  end
`else
  assign w_mul_res = r_prod;
`endif

  mdu_div_core #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept && w_is_div),
    .i_step     (r_state == ST_DIV),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_last     (w_div_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_mul)      w_next = ST_MUL;
        else if (w_accept && w_is_div) w_next = ST_DIV;
      end
      ST_MUL:  if (r_cnt == '0) w_next = ST_IDLE;
      ST_DIV:  if (w_div_last) w_next = ST_FIX;
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_dz    <= 1'b0;
      r_a_raw <= '0;
`ifdef MDU_MADD_EN
      r_acc   <= 1'b0;
      r_sub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) begin
          if (bus.op == MDU_MTHI) r_hi <= bus.a;
          if (bus.op == MDU_MTLO) r_lo <= bus.a;
          if (w_is_mul) begin
            r_prod <= w_prod;
            r_cnt  <= c_MUL_LOAD;
`ifdef MDU_MADD_EN
            r_acc  <= (bus.op == MDU_MADD) || (bus.op == MDU_MADDU) ||
                      (bus.op == MDU_MSUB) || (bus.op == MDU_MSUBU);
            r_sub  <= (bus.op == MDU_MSUB) || (bus.op == MDU_MSUBU);
`endif
          end
          if (w_is_div) begin
            r_qneg  <= w_signed & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            r_rneg  <= w_signed & bus.a[XLEN-1];
            r_dz    <= (bus.b == '0);
            r_a_raw <= bus.a;
          end
        end
        ST_MUL: begin
          if (r_cnt == '0) {r_hi, r_lo} <= w_mul_res;
          else             r_cnt <= r_cnt - CW'(1);
        end
        ST_FIX: begin
          // Divide by zero reports the raw dividend and an all-ones quotient.
          r_lo <= r_dz ? '1 : w_q_fix;
          r_hi <= r_dz ? r_a_raw : w_r_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != ST_IDLE);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mdu_iter : randomized and directed checks against an arithmetic model |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int XLEN = 32;
  localparam int MULC = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_iter_if #(.XLEN(XLEN)) bus();
  mdu_iter #(.XLEN(XLEN), .MUL_CYCLES(MULC)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit madd_en();
`ifdef MDU_MADD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Architectural effect of one instruction on HI/LO, plus expected busy length.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    logic [63:0] p;
    int sa, sb;
    sa  = a;
    sb  = b;
    lat = 0;
    case (op)
      MDU_MULT:  begin p = longint'(sa) * longint'(sb); {m_hi, m_lo} = p; lat = MULC; end
      MDU_MULTU: begin p = {32'b0, a} * {32'b0, b};     {m_hi, m_lo} = p; lat = MULC; end
      MDU_DIV, MDU_DIVU: begin
        lat = XLEN + 1;
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a;
        end else if (op == MDU_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 32'd0;
        end else if (op == MDU_DIV) begin
          m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      MDU_MTHI: m_hi = a;
      MDU_MTLO: m_lo = a;
      MDU_MADD, MDU_MSUB, MDU_MADDU, MDU_MSUBU: if (madd_en()) begin
        if (op == MDU_MADD || op == MDU_MSUB) p = longint'(sa) * longint'(sb);
        else                                  p = {32'b0, a} * {32'b0, b};
        if (op == MDU_MADD || op == MDU_MADDU) {m_hi, m_lo} = {m_hi, m_lo} + p;
        else                                   {m_hi, m_lo} = {m_hi, m_lo} - p;
        lat = MULC;
      end
      default: ;
    endcase
  endtask

  // Launch one op at a negedge; optionally pulse a stray MULT start while busy.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int pulse_at);
    int lat, cnt;
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    model(op, a, b, lat);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    cnt = 0;
    while (bus.busy && cnt < 200) begin
      if (cnt == 0) check({tag, ":hold"}, {bus.hi, bus.lo}, {old_hi, old_lo});
      bus.start = 1'b0;
      if (cnt == pulse_at) begin
        bus.start = 1'b1; bus.op = MDU_MULT; bus.a = $urandom; bus.b = $urandom;
      end
      cnt++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, ":busy_len"}, 64'(cnt), 64'(lat));
    check({tag, ":hilo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [3:0] ops [11] = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO,
                           MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU, 4'hF};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0; bus.op = 4'd0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult", MDU_MULT, 32'hFFFF_FFFD, 32'd5, -1);
    check("mult_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("divu", MDU_DIVU, 32'd100, 32'd7, -1);
    check("divu_const", {bus.hi, bus.lo}, {32'd2, 32'd14});
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, -1);
    check("div_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_zero", MDU_DIV, 32'h1234, 32'd0, -1);
    check("div_zero_const", {bus.hi, bus.lo}, {32'h1234, 32'hFFFF_FFFF});
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div_ovf_const", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});

    run_op("mtlo", MDU_MTLO, 32'h10, 32'd0, -1);
    run_op("mthi", MDU_MTHI, 32'h0, 32'd0, -1);
    run_op("maddu", MDU_MADDU, 32'd2, 32'd3, -1);
    if (madd_en()) check("maddu_const", {bus.hi, bus.lo}, 64'h16);
    else           check("maddu_ign", {bus.hi, bus.lo}, 64'h10);

    run_op("unknown", 4'hF, 32'hDEAD_BEEF, 32'd1, -1);
    run_op("div_ignore_start", MDU_DIV, 32'd1000, 32'd9, 3);

    // Asynchronous reset in the middle of a divide
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.a = 32'd77; bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_busy", 64'(bus.busy), 64'd0);
    check("post_rst_hilo", {bus.hi, bus.lo}, 64'd0);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      int pa;
      op = ops[$urandom_range(0, 10)];
      pa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_op("rand", op, pick(), pick(), pa);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
